// File: rtl/video_render_pipe.sv
// video_render_pipe: buffered pixel serialiser between the video fetcher and the palette/DAC.
// Fetched words enter a two-entry buffer (hold -> act) through a valid/ready handshake. The
// active word is split into 16-bit groups and emitted as 4-bit colour indices, one per ena_pix.
// Ports:
//   clk, rst_n            28 MHz clock, asynchronous active-low reset
//   pic_bits/pic_valid    fetched word and its valid strobe
//   pic_ready             buffer can accept a word (holding register empty)
//   ena_pix               pixel strobe
//   active                display window; pixels are consumed only while high
//   line_start            synchronous flush of the buffer and underrun flag
//   int_start             frame pulse, advances the flash counter
//   mode                  00 ZX attr, 01 hw-colour attr, 10 16-colour, 11 blank
//   border                border colour
//   pixels                registered colour index
//   underrun              sticky underrun flag
module video_render_pipe #(
    parameter int unsigned WORD_W  = 64,
    parameter int unsigned FLASH_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] pic_bits,
    input  logic              pic_valid,
    output logic              pic_ready,
    input  logic              ena_pix,
    input  logic              active,
    input  logic              line_start,
    input  logic              int_start,
    input  logic [1:0]        mode,
    input  logic [3:0]        border,
    output logic [3:0]        pixels,
    output logic              underrun
);

    localparam int unsigned G    = WORD_W / 16;
    localparam int unsigned GN_W = (G > 1) ? $clog2(G) : 1;
    localparam logic [GN_W-1:0] G_LAST = GN_W'(G - 1);

    logic [WORD_W-1:0]  hold_q, hold_n, act_q, act_n;
    logic               hold_v_q, hold_v_n, act_v_q, act_v_n;
    logic [GN_W-1:0]    gnum_q, gnum_n;
    logic [2:0]         pnum_q, pnum_n;
    logic [FLASH_W-1:0] flash_q, flash_n;
    logic [3:0]         pixels_n;
    logic               underrun_n;

    logic [15:0] grp;
    logic [7:0]  pix_byte, attr;
    logic        flash, pix_bit;
    logic [3:0]  ink, paper, pix_val;
    logic [3:0]  pnum_sum;
    logic        wrap, consume, word_done, show;

    assign pic_ready = ~hold_v_q;
    assign flash     = flash_q[FLASH_W-1];

    // Colour of the pixel addressed by the current gnum/pnum
    always_comb begin
        grp      = act_q[{gnum_q, 4'b0000} +: 16];
        pix_byte = grp[15:8];
        attr     = grp[7:0];
        ink      = {attr[6], attr[2:0]};
        paper    = {(mode[0] ? attr[7] : attr[6]), attr[5:3]};
        // pix_byte is MSB first, so bit index 7-pnum is ~pnum
        pix_bit  = pix_byte[~pnum_q] ^ ((mode == 2'b00) & flash & attr[7]);
        pix_val  = pix_bit ? ink : paper;
        if (mode[1]) begin
            // 16-colour: two pixels per byte, pnum bit 0 ignored
            case (pnum_q[2:1])
                2'd0:    pix_val = {attr[6], attr[2:0]};
                2'd1:    pix_val = {attr[7], attr[5:3]};
                2'd2:    pix_val = {pix_byte[6], pix_byte[2:0]};
                default: pix_val = {pix_byte[7], pix_byte[5:3]};
            endcase
        end
    end

    // Buffer, position, output and flag next-state
    always_comb begin
        hold_n     = hold_q;
        hold_v_n   = hold_v_q;
        act_n      = act_q;
        act_v_n    = act_v_q;
        gnum_n     = gnum_q;
        pnum_n     = pnum_q;
        pixels_n   = pixels;
        underrun_n = underrun;
        flash_n    = int_start ? flash_q + FLASH_W'(1) : flash_q;

        pnum_sum  = {1'b0, pnum_q} + (mode[1] ? 4'd2 : 4'd1);
        wrap      = pnum_sum[3];
        consume   = ena_pix & active & act_v_q & (mode != 2'b11);
        word_done = consume & wrap & (gnum_q == G_LAST);
        show      = active & act_v_q & (mode != 2'b11);

        if (line_start) begin
            hold_v_n   = 1'b0;
            act_v_n    = 1'b0;
            gnum_n     = '0;
            pnum_n     = '0;
            underrun_n = 1'b0;
        end else begin
            if (consume) begin
                pnum_n = pnum_sum[2:0];
                if (wrap) gnum_n = gnum_q + GN_W'(1);
                if (word_done) begin
                    // Seamless handoff when the holding register is full
                    gnum_n  = '0;
                    pnum_n  = '0;
                    act_v_n = hold_v_q;
                    if (hold_v_q) begin
                        act_n    = hold_q;
                        hold_v_n = 1'b0;
                    end
                end
            end else if (!act_v_q && hold_v_q) begin
                act_n    = hold_q;
                act_v_n  = 1'b1;
                hold_v_n = 1'b0;
                gnum_n   = '0;
                pnum_n   = '0;
            end

            // hold_v is 0 whenever a word is accepted, so this never races the handoff
            if (pic_valid && !hold_v_q) begin
                hold_n   = pic_bits;
                hold_v_n = 1'b1;
            end

            if (ena_pix) begin
                pixels_n = show ? pix_val : border;
                if (active && (mode != 2'b11) && !act_v_q) underrun_n = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            act_q    <= '0;
            act_v_q  <= 1'b0;
            gnum_q   <= '0;
            pnum_q   <= '0;
            flash_q  <= '0;
            pixels   <= '0;
            underrun <= 1'b0;
        end else begin
            hold_q   <= hold_n;
            hold_v_q <= hold_v_n;
            act_q    <= act_n;
            act_v_q  <= act_v_n;
            gnum_q   <= gnum_n;
            pnum_q   <= pnum_n;
            flash_q  <= flash_n;
            pixels   <= pixels_n;
            underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_video_render_pipe.sv
module tb_video_render_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pic_bits;
    logic        pic_valid, pic_ready;
    logic        ena_pix, active, line_start, int_start;
    logic [1:0]  mode;
    logic [3:0]  border, pixels;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    int flash_cnt = 0;

    video_render_pipe #(.WORD_W(64), .FLASH_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pic_bits(pic_bits), .pic_valid(pic_valid),
        .pic_ready(pic_ready), .ena_pix(ena_pix), .active(active),
        .line_start(line_start), .int_start(int_start), .mode(mode),
        .border(border), .pixels(pixels), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        act;
        logic        fl;
        logic [3:0]  brd;
        logic [63:0] word;
        logic [31:0] exp;   // eight expected pixels, first in the top nibble
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        line_start = 1'b1;
        pic_valid  = 1'b0;
        ena_pix    = 1'b0;
        step();
        line_start = 1'b0;
    endtask

    task automatic set_flash(input logic want);
        for (int i = 0; i < 32 && ((flash_cnt / 16) % 2 != int'(want)); i++) begin
            int_start = 1'b1;
            step();
            int_start = 1'b0;
            flash_cnt = (flash_cnt + 1) % 32;
        end
    endtask

    // Pixel number idx of a word, straight from the colour rules
    function automatic logic [3:0] ref_pix(input logic [63:0] w, input logic [1:0] m,
                                           input logic fl, input int idx);
        logic [15:0] grp;
        logic [7:0]  lo, hi;
        logic        b;
        int          p;
        if (m == 2'b10) begin
            grp = 16'(w >> (16 * (idx / 4)));
            lo  = grp[7:0];
            hi  = grp[15:8];
            p   = idx % 4;
            if (p == 0) return {lo[6], lo[2:0]};
            if (p == 1) return {lo[7], lo[5:3]};
            if (p == 2) return {hi[6], hi[2:0]};
            return {hi[7], hi[5:3]};
        end
        grp = 16'(w >> (16 * (idx / 8)));
        lo  = grp[7:0];
        hi  = grp[15:8];
        b   = hi[7 - (idx % 8)];
        if (m == 2'b00 && fl && lo[7]) b = ~b;
        if (b) return {lo[6], lo[2:0]};
        return {((m == 2'b00) ? lo[6] : lo[7]), lo[5:3]};
    endfunction

    // Continuous streaming with pic_valid held high and random strobe gaps
    task automatic run_random(input logic [1:0] m, input logic fl, input int nstrobes);
        logic [63:0] q[$];
        int idx = 0, strobes = 0, cycles = 0, per;
        logic xfer, stb;
        logic [3:0] exp;
        per = (m == 2'b10) ? 16 : 32;
        flush();
        set_flash(fl);
        mode      = m;
        active    = 1'b1;
        border    = 4'hD;
        pic_bits  = {$urandom, $urandom};
        pic_valid = 1'b1;
        while (strobes < nstrobes && cycles < 5000) begin
            ena_pix = (cycles >= 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
            xfer = pic_valid & pic_ready;
            stb  = ena_pix;
            step();
            cycles++;
            if (xfer) begin
                q.push_back(pic_bits);
                pic_bits = {$urandom, $urandom};
            end
            if (stb) begin
                exp = (q.size() == 0) ? border : ref_pix(q[0], m, fl, idx);
                check($sformatf("stream m%0d f%0d s%0d", m, fl, strobes), int'(pixels), int'(exp));
                idx++;
                if (idx == per) begin
                    idx = 0;
                    void'(q.pop_front());
                end
                strobes++;
            end
        end
        ena_pix   = 1'b0;
        pic_valid = 1'b0;
        check("stream budget", int'(strobes >= nstrobes), 1);
        check("stream no underrun", int'(underrun), 0);
    endtask

    initial begin
        rst_n = 1'b0; pic_bits = '0; pic_valid = 1'b0; ena_pix = 1'b0; active = 1'b0;
        line_start = 1'b0; int_start = 1'b0; mode = 2'b00; border = 4'h0;

        vecs[0] = '{2'b00, 1'b1, 1'b0, 4'h1, 64'h0000_0000_0000_A547, 32'hF8F88F8F};
        vecs[1] = '{2'b00, 1'b1, 1'b1, 4'h1, 64'h0000_0000_0000_A5C7, 32'h8F8FF8F8};
        vecs[2] = '{2'b01, 1'b1, 1'b1, 4'h1, 64'h0000_0000_0000_A587, 32'h78788787};
        vecs[3] = '{2'b00, 1'b1, 1'b1, 4'h1, 64'h0000_0000_0000_A587, 32'h07077070};
        vecs[4] = '{2'b10, 1'b1, 1'b0, 4'h1, 64'h0000_0000_0000_4321, 32'h14B00000};
        vecs[5] = '{2'b11, 1'b1, 1'b0, 4'h5, 64'h0000_0000_0000_A547, 32'h55555555};
        vecs[6] = '{2'b00, 1'b0, 1'b0, 4'h3, 64'h0000_0000_0000_A547, 32'h33333333};

        #12;
        check("reset pixels", int'(pixels), 0);
        check("reset pic_ready", int'(pic_ready), 1);
        check("reset underrun", int'(underrun), 0);
        rst_n = 1'b1;
        step();

        // Table: load one word into an empty pipe, then eight consecutive strobes
        foreach (vecs[v]) begin
            flush();
            set_flash(vecs[v].fl);
            mode      = vecs[v].mode;
            active    = vecs[v].act;
            border    = vecs[v].brd;
            pic_bits  = vecs[v].word;
            pic_valid = 1'b1;
            step();
            pic_valid = 1'b0;
            check($sformatf("vec%0d ready after accept", v), int'(pic_ready), 0);
            step();
            for (int i = 0; i < 8; i++) begin
                ena_pix = 1'b1;
                step();
                check($sformatf("vec%0d pix%0d", v, i), int'(pixels),
                      int'(4'(vecs[v].exp >> (28 - 4 * i))));
            end
            ena_pix = 1'b0;
            check($sformatf("vec%0d underrun", v), int'(underrun), 0);
        end

        run_random(2'b00, 1'b0, 200);
        run_random(2'b00, 1'b1, 200);
        run_random(2'b01, 1'b1, 200);
        run_random(2'b10, 1'b0, 200);

        // Underrun: strobe with nothing buffered
        flush();
        mode = 2'b00; active = 1'b1; border = 4'h9;
        ena_pix = 1'b1;
        step();
        ena_pix = 1'b0;
        check("underrun pixels", int'(pixels), 9);
        check("underrun set", int'(underrun), 1);
        repeat (5) step();
        check("underrun sticky", int'(underrun), 1);
        flush();
        check("underrun cleared", int'(underrun), 0);

        // line_start mid-word with the holding register full
        border = 4'h6;
        pic_bits = 64'h1111_2222_3333_4444; pic_valid = 1'b1;
        step();
        pic_bits = 64'h5555_6666_7777_8888;
        step();
        step();
        check("hold full ready", int'(pic_ready), 0);
        ena_pix = 1'b1;
        repeat (3) step();
        ena_pix = 1'b0;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        pic_valid = 1'b0;
        check("flush ready", int'(pic_ready), 1);
        check("flush underrun", int'(underrun), 0);
        ena_pix = 1'b1;
        step();
        ena_pix = 1'b0;
        check("flush border", int'(pixels), 6);

        // Asynchronous reset mid-word
        flush();
        pic_bits = 64'h0000_0000_0000_A547; pic_valid = 1'b1;
        step();
        step();
        pic_valid = 1'b0;
        ena_pix = 1'b1;
        repeat (3) step();
        ena_pix = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async rst pixels", int'(pixels), 0);
        check("async rst ready", int'(pic_ready), 1);
        #3 rst_n = 1'b1;
        flash_cnt = 0;
        active = 1'b1; ena_pix = 1'b1;
        step();
        ena_pix = 1'b0;
        check("after rst border", int'(pixels), int'(border));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
